voxel_store: RTL and testbench

- Parametrised successor to the world block cache: stores one BLOCK_BITS-wide block type per voxel of a SIZE_X×SIZE_Y×SIZE_Z world in a single dual-port BRAM.
- Write side: a bulk loader that takes a UART byte stream, a bulk clear engine, and a random-access single-voxel write port.
- Read side: NUM_RD independent request channels sharing one BRAM read port through a round-robin arbiter, with fixed-latency tagged responses.
- Sits between the UART receiver/world loader and the renderer/physics consumers.

---
 rtl/voxel_store.sv | 172 +++++++++++++++++
 tb/tb_voxel_store.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voxel_store.sv
// Voxel block-type store: one BLOCK_BITS entry per (x,y,z) in a single dual-port RAM,
// filled by a UART bulk loader, a clear engine or a random write port, read by NUM_RD arbitrated channels.
module voxel_store #(
   parameter int SIZE_X     = 64,
   parameter int SIZE_Y     = 64,
   parameter int SIZE_Z     = 16,
   parameter int BLOCK_BITS = 5,
   parameter int NUM_RD     = 2,
   localparam int XW = $clog2(SIZE_X),
   localparam int YW = $clog2(SIZE_Y),
   localparam int ZW = $clog2(SIZE_Z)
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     load_start_in,
   input  logic                     clear_start_in,
   input  logic [7:0]               load_data_in,
   input  logic                     load_valid_in,
   output logic                     load_done_out,
   output logic                     busy_out,
   input  logic                     wr_valid_in,
   output logic                     wr_ready_out,
   input  logic [XW-1:0]            wr_x_in,
   input  logic [YW-1:0]            wr_y_in,
   input  logic [ZW-1:0]            wr_z_in,
   input  logic [BLOCK_BITS-1:0]    wr_data_in,
   input  logic [NUM_RD-1:0]        rd_valid_in,
   output logic [NUM_RD-1:0]        rd_ready_out,
   input  logic [NUM_RD*XW-1:0]     rd_x_in,
   input  logic [NUM_RD*YW-1:0]     rd_y_in,
   input  logic [NUM_RD*ZW-1:0]     rd_z_in,
   output logic [NUM_RD-1:0]        rsp_valid_out,
   output logic [BLOCK_BITS-1:0]    rsp_data_out,
   output logic [1:0]               state_out
);

   // Handshakes: a write or read request transfers in any cycle where valid && ready;
   // the requester holds valid and its coordinates stable until then, and ready never
   // waits on anything but the current valid inputs, the arbiter pointer and the state.

   localparam int AW    = XW + YW + ZW;
   localparam int DEPTH = SIZE_X * SIZE_Y * SIZE_Z;
   localparam int PW    = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CLEAR = 2'd2} state_t;

   state_t                  state, state_nxt;
   logic [1:0]              rst_sync;
   logic                    rst_n;
   logic [AW-1:0]           cnt;
   logic                    last;
   logic                    done_q;
   logic [PW-1:0]           ptr, ptr_nxt, gnt_idx;
   logic [NUM_RD-1:0]       rd_gnt, rd_v1;
   logic [AW-1:0]           rd_addr;
   logic                    found;
   logic                    mem_we;
   logic [AW-1:0]           mem_waddr;
   logic [BLOCK_BITS-1:0]   mem_wdata;
   logic [BLOCK_BITS-1:0]   rd_q;
   logic [BLOCK_BITS-1:0]   mem [DEPTH];

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) rst_sync <= 2'b00;
      else         rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   assign last = (cnt == LAST_ADDR);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clear_start_in)     state_nxt = CLEAR;
                  else if (load_start_in) state_nxt = LOAD;
         LOAD:    if (load_valid_in && last) state_nxt = IDLE;
         CLEAR:   if (last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_out     = (state != IDLE);
      wr_ready_out = (state == IDLE);
      mem_we       = 1'b0;
      mem_waddr    = '0;
      mem_wdata    = '0;
      case (state)
         LOAD: begin
            mem_we    = load_valid_in;
            mem_waddr = cnt;
            mem_wdata = load_data_in[BLOCK_BITS-1:0];
         end
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
         end
         default: begin
            mem_we    = wr_valid_in;
            mem_waddr = {wr_x_in, wr_y_in, wr_z_in};
            mem_wdata = wr_data_in;
         end
      endcase

      // Round-robin: scan from the pointer, first requester wins.
      rd_gnt  = '0;
      gnt_idx = '0;
      rd_addr = '0;
      found   = 1'b0;
      if (state == IDLE) begin
         for (int off = 0; off < NUM_RD; off++) begin
            int idx;
            idx = int'(ptr) + off;
            if (idx >= NUM_RD) idx = idx - NUM_RD;
            if (!found && rd_valid_in[idx]) begin
               found       = 1'b1;
               rd_gnt[idx] = 1'b1;
               gnt_idx     = PW'(idx);
               rd_addr     = {rd_x_in[idx*XW +: XW], rd_y_in[idx*YW +: YW], rd_z_in[idx*ZW +: ZW]};
            end
         end
      end
      ptr_nxt = (gnt_idx == PW'(NUM_RD - 1)) ? '0 : gnt_idx + PW'(1);
   end

   assign rd_ready_out  = rd_gnt;
   assign load_done_out = done_q;
   assign state_out     = state;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         done_q        <= 1'b0;
         ptr           <= '0;
         rd_v1         <= '0;
         rsp_valid_out <= '0;
         rsp_data_out  <= '0;
      end else begin
         case (state)
            LOAD:    if (load_valid_in) cnt <= cnt + AW'(1);
            CLEAR:   cnt <= cnt + AW'(1);
            default: cnt <= '0;
         endcase
         done_q <= ((state == LOAD) && load_valid_in && last) || ((state == CLEAR) && last);
         if (|rd_gnt) ptr <= ptr_nxt;
         rd_v1         <= rd_gnt;
         rsp_valid_out <= rd_v1;
         if (|rd_v1) rsp_data_out <= rd_q;
      end
   end

   // Write and read share an edge, so a same-address read returns the old contents.
   always_ff @(posedge clk_in) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      if (|rd_gnt) rd_q <= mem[rd_addr];
   end

   generate
      if (BLOCK_BITS < 8) begin : g_unused
         logic unused_load_bits;
         assign unused_load_bits = ^load_data_in[7:BLOCK_BITS];
      end
   endgenerate

endmodule

// File: tb/tb_voxel_store.sv
// Directed bench for voxel_store on a reduced 8x4x4 world: clear, bulk load, arbitration,
// read/write hazard, hold-off during load and mid-load reset.
module tb_voxel_store;

  localparam int SX = 8, SY = 4, SZ = 4, BB = 5, NR = 2;
  localparam int XW = 3, YW = 2, ZW = 2, DEPTH = 128;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic              load_start_in = 1'b0, clear_start_in = 1'b0;
  logic [7:0]        load_data_in = '0;
  logic              load_valid_in = 1'b0;
  logic              load_done_out, busy_out;
  logic              wr_valid_in = 1'b0;
  logic              wr_ready_out;
  logic [XW-1:0]     wr_x_in = '0;
  logic [YW-1:0]     wr_y_in = '0;
  logic [ZW-1:0]     wr_z_in = '0;
  logic [BB-1:0]     wr_data_in = '0;
  logic [NR-1:0]     rd_valid_in = '0;
  logic [NR-1:0]     rd_ready_out;
  logic [NR*XW-1:0]  rd_x_in = '0;
  logic [NR*YW-1:0]  rd_y_in = '0;
  logic [NR*ZW-1:0]  rd_z_in = '0;
  logic [NR-1:0]     rsp_valid_out;
  logic [BB-1:0]     rsp_data_out;
  logic [1:0]        state_out;

  voxel_store #(.SIZE_X(SX), .SIZE_Y(SY), .SIZE_Z(SZ), .BLOCK_BITS(BB), .NUM_RD(NR)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .load_start_in(load_start_in), .clear_start_in(clear_start_in),
    .load_data_in(load_data_in), .load_valid_in(load_valid_in),
    .load_done_out(load_done_out), .busy_out(busy_out),
    .wr_valid_in(wr_valid_in), .wr_ready_out(wr_ready_out),
    .wr_x_in(wr_x_in), .wr_y_in(wr_y_in), .wr_z_in(wr_z_in), .wr_data_in(wr_data_in),
    .rd_valid_in(rd_valid_in), .rd_ready_out(rd_ready_out),
    .rd_x_in(rd_x_in), .rd_y_in(rd_y_in), .rd_z_in(rd_z_in),
    .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out),
    .state_out(state_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  int n_cmp = 0, n_bad = 0, cyc = 0, done_cnt = 0;
  logic [BB-1:0] exp_q[$];
  int gnt_cyc_q[$];
  int gnt_ch_q[$];
  int mon_c, mon_ch;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk_in) begin
    if (!rst_in) begin
      gnt_cyc_q.delete();
      gnt_ch_q.delete();
      exp_q.delete();
    end else begin
      if (load_done_out) done_cnt++;
      if (rsp_valid_out != '0) begin
        if (gnt_cyc_q.size() == 0) check_eq("rsp_unexpected", 32'(rsp_valid_out), 0);
        else begin
          mon_c  = gnt_cyc_q.pop_front();
          mon_ch = gnt_ch_q.pop_front();
          check_eq("rsp_latency", 32'(cyc - mon_c), 2);
          check_eq("rsp_channel", 32'(rsp_valid_out), 32'(1) << mon_ch);
          if (exp_q.size() == 0) check_eq("rsp_expected_avail", 32'(exp_q.size()), 1);
          else check_eq("rsp_data", 32'(rsp_data_out), 32'(exp_q.pop_front()));
        end
      end
      for (int i = 0; i < NR; i++)
        if (rd_ready_out[i]) begin
          gnt_cyc_q.push_back(cyc);
          gnt_ch_q.push_back(i);
        end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_rd(input int ch, input int x, input int y, input int z);
    rd_x_in[ch*XW +: XW] = XW'(x);
    rd_y_in[ch*YW +: YW] = YW'(y);
    rd_z_in[ch*ZW +: ZW] = ZW'(z);
  endtask

  task automatic read_one(input int ch, input int x, input int y, input int z, input logic [BB-1:0] exp);
    int n;
    set_rd(ch, x, y, z);
    exp_q.push_back(exp);
    rd_valid_in[ch] = 1'b1;
    n = 0;
    @(negedge clk_in);
    while (!rd_ready_out[ch] && n < 200) begin
      n++;
      @(negedge clk_in);
    end
    check_eq("rd_grant_wait", 32'(rd_ready_out[ch]), 1);
    tick();
    rd_valid_in[ch] = 1'b0;
    repeat (3) tick();
  endtask

  // sel 0: k|0xE0, 1: 255-k, 2: k+5. hold=1 also raises a write and a ch1 read
  // with the first byte and checks they stay held off for the whole load.
  task automatic load_all(input int sel, input int max_gap, input bit hold);
    int gap;
    load_start_in = 1'b1;
    tick();
    load_start_in = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (gap) begin
        load_valid_in = 1'b0;
        tick();
      end
      load_valid_in = 1'b1;
      case (sel)
        0:       load_data_in = 8'(k) | 8'hE0;
        1:       load_data_in = 8'(255 - k);
        default: load_data_in = 8'(k + 5);
      endcase
      if (hold && k == 0) begin
        wr_valid_in    = 1'b1;
        rd_valid_in[1] = 1'b1;
      end
      if (hold) begin
        @(negedge clk_in);
        check_eq("hold_wr_ready", 32'(wr_ready_out), 0);
        check_eq("hold_rd_ready", 32'(rd_ready_out), 0);
      end
      tick();
    end
    load_valid_in = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int busy_n, done_before;

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_eq("rst_busy", 32'(busy_out), 0);
    check_eq("rst_done", 32'(load_done_out), 0);
    check_eq("rst_rsp_valid", 32'(rsp_valid_out), 0);
    check_eq("rst_rsp_data", 32'(rsp_data_out), 0);
    check_eq("rst_state", 32'(state_out), 0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    repeat (4) tick();
    check_eq("idle_wr_ready", 32'(wr_ready_out), 1);

    // 1: clear
    clear_start_in = 1'b1;
    tick();
    clear_start_in = 1'b0;
    busy_n = 0;
    @(negedge clk_in);
    while (!load_done_out && busy_n < DEPTH + 20) begin
      if (busy_out) busy_n++;
      @(negedge clk_in);
    end
    check_eq("clear_busy_cycles", 32'(busy_n), DEPTH);
    check_eq("clear_done_pulse", 32'(load_done_out), 1);
    check_eq("clear_busy_at_done", 32'(busy_out), 0);
    @(negedge clk_in);
    check_eq("clear_done_one_cycle", 32'(load_done_out), 0);
    tick();
    read_one(0, 7, 3, 3, 5'd0);

    // 2: bulk load with gaps
    done_before = done_cnt;
    load_all(0, 2, 1'b0);
    @(negedge clk_in);
    check_eq("load_done_after_last", 32'(load_done_out), 1);
    check_eq("load_busy_at_done", 32'(busy_out), 0);
    repeat (3) tick();
    check_eq("load_done_count", 32'(done_cnt - done_before), 1);
    read_one(0, 0, 0, 1, 5'd1);
    read_one(0, 1, 0, 0, 5'd16);
    read_one(0, 0, 1, 3, 5'd7);
    read_one(1, 7, 3, 3, 5'd31);

    // 3: both channels requesting, pointer now at 0
    set_rd(0, 1, 0, 0);
    set_rd(1, 0, 1, 3);
    rd_valid_in = 2'b11;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back((i % 2 == 0) ? 5'd16 : 5'd7);
      @(negedge clk_in);
      check_eq("rr_grant", 32'(rd_ready_out), (i % 2 == 0) ? 1 : 2);
      tick();
    end
    rd_valid_in = 2'b00;
    repeat (4) tick();

    // 4: same-cycle write and read of (5,2,3), old value 27
    wr_x_in = 3'd5; wr_y_in = 2'd2; wr_z_in = 2'd3; wr_data_in = 5'd9;
    wr_valid_in = 1'b1;
    set_rd(0, 5, 2, 3);
    rd_valid_in[0] = 1'b1;
    exp_q.push_back(5'd27);
    @(negedge clk_in);
    check_eq("hz_wr_ready", 32'(wr_ready_out), 1);
    check_eq("hz_rd_grant", 32'(rd_ready_out), 1);
    tick();
    wr_valid_in = 1'b0;
    exp_q.push_back(5'd9);
    @(negedge clk_in);
    check_eq("hz_reread_grant", 32'(rd_ready_out), 1);
    tick();
    rd_valid_in[0] = 1'b0;
    repeat (4) tick();
    check_eq("rsp_data_held", 32'(rsp_data_out), 9);
    check_eq("rsp_valid_idle", 32'(rsp_valid_out), 0);

    // 5: held write (1,1,1)=3 and held ch1 read of (0,0,2) during load
    wr_x_in = 3'd1; wr_y_in = 2'd1; wr_z_in = 2'd1; wr_data_in = 5'd3;
    set_rd(1, 0, 0, 2);
    exp_q.push_back(5'd29);
    load_all(1, 0, 1'b1);
    @(negedge clk_in);
    check_eq("held_done", 32'(load_done_out), 1);
    check_eq("held_rd_first_idle", 32'(rd_ready_out), 2);
    check_eq("held_wr_first_idle", 32'(wr_ready_out), 1);
    tick();
    rd_valid_in = 2'b00;
    wr_valid_in = 1'b0;
    repeat (3) tick();
    read_one(0, 1, 1, 1, 5'd3);
    read_one(1, 0, 0, 3, 5'd28);

    // 6: reset mid-load with a read in flight
    set_rd(0, 0, 0, 1);
    rd_valid_in[0] = 1'b1;
    load_start_in = 1'b1;
    @(negedge clk_in);
    check_eq("rst6_grant", 32'(rd_ready_out), 1);
    tick();
    rd_valid_in = 2'b00;
    load_start_in = 1'b0;
    load_valid_in = 1'b1;
    load_data_in = 8'h0A;
    #1;
    check_eq("rst6_busy_before", 32'(busy_out), 1);
    #1;
    rst_in = 1'b0;
    #1;
    check_eq("rst6_busy_drop", 32'(busy_out), 0);
    check_eq("rst6_state", 32'(state_out), 0);
    check_eq("rst6_done", 32'(load_done_out), 0);
    check_eq("rst6_rsp_valid", 32'(rsp_valid_out), 0);
    load_valid_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      check_eq("rst6_rsp_cancel", 32'(rsp_valid_out), 0);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    repeat (4) begin
      @(negedge clk_in);
      check_eq("rst6_rsp_after", 32'(rsp_valid_out), 0);
      check_eq("rst6_busy_after", 32'(busy_out), 0);
    end
    tick();
    load_all(2, 1, 1'b0);
    @(negedge clk_in);
    check_eq("reload_done", 32'(load_done_out), 1);
    repeat (2) tick();
    read_one(0, 0, 0, 0, 5'd5);
    read_one(0, 0, 0, 1, 5'd6);
    read_one(1, 1, 2, 3, 5'd0);

    repeat (4) tick();
    check_eq("exp_q_drained", 32'(exp_q.size()), 0);
    check_eq("grants_drained", 32'(gnt_cyc_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
